// File: rtl/ps2_pkg.sv
// ps2_pkg: shared byte constants, key event layout and receiver states.
package ps2_pkg;
  localparam logic [7:0] BYTE_E0 = 8'hE0;
  localparam logic [7:0] BYTE_F0 = 8'hF0;
  localparam int EVT_W = 10;
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_evt_t;
  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} rx_state_e;
  // Keyboard command/status replies that never represent a key.
  function automatic logic is_ignored(input logic [7:0] b);
    return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'hE1};
  endfunction
endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronises and filters the PS/2 lines, then deframes
// 11-bit frames into bytes with parity, stop-bit and timeout checking.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int P_FILTER_LEN     = 4,
  parameter int P_TIMEOUT_CYCLES = 50000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);
  localparam int FW = $clog2(P_FILTER_LEN + 1);
  localparam int TW = $clog2(P_TIMEOUT_CYCLES + 1);
  logic [1:0] sync1_q, sync2_q, filt_q, filt_d;
  logic [1:0][FW-1:0] cnt_q, cnt_d;
  logic fclk_prev_q, fall, din;
  rx_state_e state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic par_ok_q, par_ok_d, valid_q, valid_d, err_q, err_d;
  logic [TW-1:0] tmo_q, tmo_d;
  // Index 0 is the clock line, index 1 the data line.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    for (int i = 0; i < 2; i++)
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == FW'(P_FILTER_LEN - 1)) filt_d[i] = sync2_q[i];
        else cnt_d[i] = cnt_q[i] + 1'b1;
      end
  end
  assign fall = fclk_prev_q & ~filt_q[0];
  assign din  = filt_q[1];
  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_ok_d = par_ok_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    tmo_d    = (state_q == ST_IDLE || fall) ? '0 : tmo_q + 1'b1;
    if (fall) begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = din ? ST_IDLE : ST_DATA;
          bit_d   = '0;
        end
        ST_DATA: begin
          shift_d = {din, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          state_d = (bit_q == 3'd7) ? ST_PARITY : ST_DATA;
        end
        ST_PARITY: begin
          par_ok_d = ^shift_q ^ din;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          valid_d = din & par_ok_q;
          err_d   = ~(din & par_ok_q);
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && tmo_q == TW'(P_TIMEOUT_CYCLES - 1)) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end
  end
  // Lines idle high, so the filter resets to 1 to avoid a spurious edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q     <= 2'b11;
      sync2_q     <= 2'b11;
      filt_q      <= 2'b11;
      cnt_q       <= '0;
      fclk_prev_q <= 1'b1;
      state_q     <= ST_IDLE;
      bit_q       <= '0;
      shift_q     <= '0;
      par_ok_q    <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      tmo_q       <= '0;
    end else begin
      sync1_q     <= {ps2_data_i, ps2_clk_i};
      sync2_q     <= sync1_q;
      filt_q      <= filt_d;
      cnt_q       <= cnt_d;
      fclk_prev_q <= filt_q[0];
      state_q     <= state_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      par_ok_q    <= par_ok_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
    end
  end
  assign byte_o       = shift_q;
  assign byte_valid_o = valid_q;
  assign frame_err_o  = err_q;
endmodule

// File: rtl/ps2_key_event_queue.sv
// ps2_key_event_queue: PS/2 receiver, E0/F0 prefix decoder, optional
// typematic repeat filter and first-word fall-through key event FIFO.
module ps2_key_event_queue
  import ps2_pkg::*;
#(
  parameter int P_FIFO_DEPTH      = 16,
  parameter int P_FILTER_LEN      = 4,
  parameter int P_TIMEOUT_CYCLES  = 50000,
  parameter int P_SUPPRESS_REPEAT = 1
) (
  input  logic                            CLK_50MHZ,
  input  logic                            RST_N,
  input  logic                            PS2CLK,
  input  logic                            DATA,
  input  logic                            POP,
  input  logic                            CLR_ERR,
  output logic                            KEY_VALID,
  output logic [7:0]                      KEY_CODE,
  output logic                            KEY_EXT,
  output logic                            KEY_RELEASED,
  output logic [$clog2(P_FIFO_DEPTH):0]   FIFO_COUNT,
  output logic                            OVERFLOW,
  output logic                            FRAME_ERR
);
  localparam int AW = $clog2(P_FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [7:0] rx_byte;
  logic rx_valid, rx_err;
  ps2_frame_rx #(.P_FILTER_LEN(P_FILTER_LEN), .P_TIMEOUT_CYCLES(P_TIMEOUT_CYCLES)) u_rx (
    .clk_i(CLK_50MHZ), .rst_ni(RST_N), .ps2_clk_i(PS2CLK), .ps2_data_i(DATA),
    .byte_o(rx_byte), .byte_valid_o(rx_valid), .frame_err_o(rx_err)
  );
  logic ext_q, ext_d, brk_q, brk_d, held_vld_q, held_vld_d;
  logic [8:0] held_q, held_d;
  logic ev_ok, held_match, drop, push, pop_ok, full, wr;
  key_evt_t evt, head;
  key_evt_t mem_q [P_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic ovf_q, ovf_d, ferr_q, ferr_d;
  always_comb begin
    evt        = '{ext: ext_q, brk: brk_q, code: rx_byte};
    ev_ok      = rx_valid && rx_byte != BYTE_E0 && rx_byte != BYTE_F0 && !is_ignored(rx_byte);
    ext_d      = rx_valid ? (rx_byte == BYTE_E0 || (rx_byte == BYTE_F0 && ext_q)) : ext_q;
    brk_d      = rx_valid ? (rx_byte == BYTE_F0 || (rx_byte == BYTE_E0 && brk_q)) : brk_q;
    held_match = held_vld_q && held_q == {evt.ext, evt.code};
    drop       = P_SUPPRESS_REPEAT != 0 && !evt.brk && held_match;
    push       = ev_ok && !drop;
    held_vld_d = !ev_ok ? held_vld_q : !evt.brk ? 1'b1 : held_match ? 1'b0 : held_vld_q;
    held_d     = (ev_ok && !evt.brk) ? {evt.ext, evt.code} : held_q;
    // A pop frees the full slot in the same cycle, so a simultaneous push fits.
    pop_ok     = POP && count_q != '0;
    full       = count_q == CW'(P_FIFO_DEPTH);
    wr         = push && (!full || pop_ok);
    count_d    = count_q + CW'(wr) - CW'(pop_ok);
    wr_ptr_d   = wr_ptr_q + AW'(wr);
    rd_ptr_d   = rd_ptr_q + AW'(pop_ok);
    ovf_d      = (push && !wr) ? 1'b1 : CLR_ERR ? 1'b0 : ovf_q;
    ferr_d     = rx_err ? 1'b1 : CLR_ERR ? 1'b0 : ferr_q;
    head       = count_q != '0 ? mem_q[rd_ptr_q] : '0;
  end
  always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      held_vld_q <= 1'b0;
      held_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      held_vld_q <= held_vld_d;
      held_q     <= held_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      ferr_q     <= ferr_d;
    end
  end
  always_ff @(posedge CLK_50MHZ) if (wr) mem_q[wr_ptr_q] <= evt;
  assign KEY_VALID    = count_q != '0;
  assign KEY_CODE     = head.code;
  assign KEY_EXT      = head.ext;
  assign KEY_RELEASED = head.brk;
  assign FIFO_COUNT   = count_q;
  assign OVERFLOW     = ovf_q;
  assign FRAME_ERR    = ferr_q;
endmodule

// File: tb/tb_ps2_key_event_queue.sv
// tb_ps2_key_event_queue: directed PS/2 frames into two queues, one with
// repeat suppression on and one with it off.
module tb_ps2_key_event_queue;
  logic clk = 1'b0, rst_n = 1'b0, ps2clk = 1'b1, data = 1'b1;
  logic pop = 1'b0, pop_nr = 1'b0, clr_err = 1'b0;
  logic kv, kx, kr, ovf, ferr, kv_nr, kx_nr, kr_nr, ovf_nr, ferr_nr;
  logic [7:0] kc, kc_nr;
  logic [4:0] cnt, cnt_nr;
  int n_vec = 0, n_bad = 0;
  always #10 clk = ~clk;
  ps2_key_event_queue dut (
    .CLK_50MHZ(clk), .RST_N(rst_n), .PS2CLK(ps2clk), .DATA(data), .POP(pop), .CLR_ERR(clr_err),
    .KEY_VALID(kv), .KEY_CODE(kc), .KEY_EXT(kx), .KEY_RELEASED(kr), .FIFO_COUNT(cnt),
    .OVERFLOW(ovf), .FRAME_ERR(ferr)
  );
  ps2_key_event_queue #(.P_SUPPRESS_REPEAT(0)) dut_nr (
    .CLK_50MHZ(clk), .RST_N(rst_n), .PS2CLK(ps2clk), .DATA(data), .POP(pop_nr), .CLR_ERR(clr_err),
    .KEY_VALID(kv_nr), .KEY_CODE(kc_nr), .KEY_EXT(kx_nr), .KEY_RELEASED(kr_nr), .FIFO_COUNT(cnt_nr),
    .OVERFLOW(ovf_nr), .FRAME_ERR(ferr_nr)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // mode 1: check push latency at the stop edge; mode 2: pulse POP in the push cycle
  task automatic send(input logic [7:0] b, input int mode = 0, input int nbits = 11, input bit badpar = 1'b0);
    logic [10:0] bits;
    bits = {1'b1, ~^b ^ badpar, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk) data = bits[i];
      repeat (5) @(negedge clk);
      ps2clk = 1'b0;
      if (i == 10 && mode == 1) begin
        repeat (7) @(posedge clk);
        #1 chk("latency_lo", kv, 1'b0);
        @(posedge clk);
        #1 chk("latency_hi", kv, 1'b1);
      end else if (i == 10 && mode == 2) begin
        repeat (7) @(posedge clk);
        @(negedge clk) pop = 1'b1;
        @(negedge clk) pop = 1'b0;
      end
      repeat (10) @(negedge clk);
      ps2clk = 1'b1;
    end
    @(negedge clk) data = 1'b1;
    repeat (20) @(negedge clk);
  endtask
  task automatic do_pop();
    @(negedge clk) pop = 1'b1;
    @(negedge clk) pop = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 40 && (kv || kv_nr); i++) begin
      @(negedge clk) begin pop = 1'b1; pop_nr = 1'b1; end
      @(negedge clk) begin pop = 1'b0; pop_nr = 1'b0; end
    end
  endtask
  task automatic clear_err();
    @(negedge clk) clr_err = 1'b1;
    @(negedge clk) clr_err = 1'b0;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", kv, 1'b0);
    chk("rst_count", cnt, 5'd0);
    chk("rst_code", kc, 8'h00);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_ferr", ferr, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send(8'h1C, 1);
    chk("make_code", kc, 8'h1C);
    chk("make_ext", kx, 1'b0);
    chk("make_rel", kr, 1'b0);
    chk("make_count", cnt, 5'd1);
    do_pop();
    chk("pop_count", cnt, 5'd0);
    chk("pop_valid", kv, 1'b0);
    chk("pop_code", kc, 8'h00);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("ext_count", cnt, 5'd1);
    chk("ext_code", kc, 8'h75);
    chk("ext_ext", kx, 1'b1);
    chk("ext_rel", kr, 1'b1);
    do_pop();
    send(8'hF0); send(8'h1C);
    drain();
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
    chk("rep_count", cnt, 5'd2);
    chk("rep_nr_count", cnt_nr, 5'd4);
    chk("rep_first_code", kc, 8'h1C);
    chk("rep_first_rel", kr, 1'b0);
    do_pop();
    chk("rep_second_code", kc, 8'h1C);
    chk("rep_second_rel", kr, 1'b1);
    drain();
    send(8'h1C, 0, 11, 1'b1);
    chk("par_count", cnt, 5'd0);
    chk("par_ferr", ferr, 1'b1);
    clear_err();
    chk("par_clr", ferr, 1'b0);
    send(8'h1C, 0, 4);
    repeat (49000) @(negedge clk);
    chk("tmo_early", ferr, 1'b0);
    repeat (1500) @(negedge clk);
    chk("tmo_ferr", ferr, 1'b1);
    send(8'h2B);
    chk("tmo_next_count", cnt, 5'd1);
    chk("tmo_next_code", kc, 8'h2B);
    chk("tmo_next_rel", kr, 1'b0);
    clear_err();
    chk("tmo_clr", ferr, 1'b0);
    drain();
    for (int i = 0; i < 17; i++) send(8'h30 + 8'(i));
    chk("ovf_count", cnt, 5'd16);
    chk("ovf_flag", ovf, 1'b1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ovf_pop%0d", i), kc, 8'h30 + 8'(i));
      do_pop();
    end
    chk("ovf_empty", kv, 1'b0);
    chk("ovf_sticky", ovf, 1'b1);
    clear_err();
    chk("ovf_clr", ovf, 1'b0);
    drain();
    for (int i = 0; i < 16; i++) send(8'h50 + 8'(i));
    chk("full_count", cnt, 5'd16);
    send(8'h60, 2);
    chk("full_pp_count", cnt, 5'd16);
    chk("full_pp_ovf", ovf, 1'b0);
    chk("full_pp_head", kc, 8'h51);
    for (int i = 0; i < 15; i++) do_pop();
    chk("full_pp_tail", kc, 8'h60);
    chk("full_pp_last", cnt, 5'd1);
    do_pop();
    chk("full_pp_empty", kv, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
